// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_e;

  // 50 MHz system clock at 19200 baud.
  localparam int unsigned DEFAULT_CLK_PER_BIT = 2604;

  // bits_xor is the XOR of all data bits and the received parity bit.
  function automatic logic parity_error(parity_e mode, logic bits_xor);
    logic err;
    err = 1'b0;
    unique case (mode)
      PAR_EVEN: err = bits_xor;
      PAR_ODD:  err = ~bits_xor;
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin plus one history flop
// for falling-edge detection. All flops reset to the idle line level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  // Synchroniser chain and previous-sample history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      meta_q    <= rx;
      rx_s_q    <= meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_s = rx_s_q;
  assign fall = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: bit period, data width and parity are
// parameters. Received word and status flags are registered and only change
// on frame completion, consumer acknowledge (clr_rdy) or reset.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int unsigned DATA_BITS   = 8,
  parameter parity_e     PARITY      = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned BCW   = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(CLK_PER_BIT / 2);
  localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  rx_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BCW-1:0]         bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_bit_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rdy_q;
  logic                   frame_err_q;
  logic                   parity_err_q;
  logic                   overrun_q;
  logic                   par_err_d;
  logic                   baud_zero;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign baud_zero = (cnt_q == '0);

  // Parity verdict for the frame currently held in the shift register.
  always_comb begin
    par_err_d = 1'b0;
    par_err_d = parity_error(PARITY, ^{shift_q, par_bit_q});
  end

  // Receive FSM, baud/bit counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      rx_data_q    <= '0;
      rdy_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // Acknowledge clears status; a completion later in this block
      // overrides it so a frame finishing in the same cycle is never lost.
      if (clr_rdy) begin
        rdy_q        <= 1'b0;
        frame_err_q  <= 1'b0;
        parity_err_q <= 1'b0;
        overrun_q    <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q   <= START;
            cnt_q     <= HALF_C;
            bit_cnt_q <= '0;
          end
        end

        START: begin
          if (baud_zero) begin
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              cnt_q   <= RELOAD_C;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        DATA: begin
          if (baud_zero) begin
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_q     <= RELOAD_C;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= (PARITY == PAR_NONE) ? STOP : PAR;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        PAR: begin
          if (baud_zero) begin
            par_bit_q <= rx_s;
            cnt_q     <= RELOAD_C;
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
          if (baud_zero) begin
            state_q      <= IDLE;
            rx_data_q    <= shift_q;
            frame_err_q  <= ~rx_s;
            parity_err_q <= par_err_d;
            rdy_q        <= 1'b1;
            overrun_q    <= overrun_q | (rdy_q & ~clr_rdy);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rdy        = rdy_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E1 instance, both at 16
// clocks per bit, driven by directed and random frames. Expected outputs
// come from a frame-level model: each sent frame schedules one completion
// at its computed cycle; clr_rdy clears unless a completion coincides.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0   = 1'b1;
  logic       rx1   = 1'b1;
  logic       clr0  = 1'b0;
  logic       clr1  = 1'b0;
  logic [7:0] d0;
  logic [6:0] d1;
  logic       rdy0, fe0, pe0, ov0;
  logic       rdy1, fe1, pe1, ov1;

  uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_NONE)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .clr_rdy(clr0), .rx_data(d0),
    .rdy(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(7), .PARITY(PAR_EVEN)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .RX(rx1), .clr_rdy(clr1), .rx_data(d1),
    .rdy(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int data;
    bit fe;
    bit pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int m_data[2];
  bit m_rdy[2];
  bit m_fe[2];
  bit m_pe[2];
  bit m_ov[2];
  int last_rise0 = -1;

  // Per-cycle model update and comparison, sampled 1 time unit after posedge.
  initial begin
    bit clr_s[2];
    bit rs;
    bit prev_rdy0;
    bit comp;
    exp_t e;
    int now;
    logic [31:0] expv;
    logic [31:0] gotv;
    prev_rdy0 = 1'b0;
    forever begin
      @(posedge clk);
      clr_s[0] = clr0;
      clr_s[1] = clr1;
      rs = rst_n;
      #1;
      now = cyc;
      for (int i = 0; i < 2; i++) begin
        comp = 1'b0;
        if (!rs) begin
          m_data[i] = 0; m_rdy[i] = 0; m_fe[i] = 0; m_pe[i] = 0; m_ov[i] = 0;
          if (i == 0) q0.delete(); else q1.delete();
        end else begin
          if (i == 0 && q0.size() > 0 && q0[0].cyc == now) begin e = q0.pop_front(); comp = 1'b1; end
          if (i == 1 && q1.size() > 0 && q1[0].cyc == now) begin e = q1.pop_front(); comp = 1'b1; end
          if (comp) begin
            m_ov[i]   = m_ov[i] | (m_rdy[i] & ~clr_s[i]);
            m_rdy[i]  = 1'b1;
            m_data[i] = e.data;
            m_fe[i]   = e.fe;
            m_pe[i]   = e.pe;
          end else if (clr_s[i]) begin
            m_rdy[i] = 0; m_fe[i] = 0; m_pe[i] = 0; m_ov[i] = 0;
          end
        end
        expv = (32'(m_data[i]) << 4) | {28'd0, m_rdy[i], m_fe[i], m_pe[i], m_ov[i]};
        if (i == 0) gotv = 32'({d0, rdy0, fe0, pe0, ov0});
        else        gotv = 32'({d1, rdy1, fe1, pe1, ov1});
        check(i == 0 ? "model_8n1" : "model_7e1", gotv, expv);
      end
      if (rdy0 === 1'b1 && !prev_rdy0) last_rise0 = now;
      prev_rdy0 = (rdy0 === 1'b1);
    end
  end

  task automatic set_line(int idx, logic v, logic c);
    if (idx == 0) begin rx0 = v; clr0 = c; end
    else          begin rx1 = v; clr1 = c; end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      rx0 = 1'b1; rx1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    end
  endtask

  task automatic pulse_clr(int idx);
    @(negedge clk);
    set_line(idx, 1'b1, 1'b1);
    @(negedge clk);
    set_line(idx, 1'b1, 1'b0);
  endtask

  // Sends one frame; clr_off >= 1 asserts clr_rdy so that it is sampled
  // on edge (start + clr_off). Returns the cycle value at the RX fall.
  task automatic send_frame(int idx, int data, bit par_ok, bit stop_ok,
                            int clr_off, output int c);
    int db;
    int hp;
    int nbits;
    int md;
    bit px;
    logic [11:0] frame;
    exp_t e;
    db    = (idx == 0) ? 8 : 7;
    hp    = (idx == 0) ? 0 : 1;
    nbits = db + 2 + hp;
    md    = data & ((1 << db) - 1);
    px    = 1'b0;
    frame = '0;
    for (int j = 0; j < db; j++) begin
      frame[1+j] = md[j];
      px ^= md[j];
    end
    if (hp == 1) frame[1+db] = px ^ ~par_ok;
    frame[1+db+hp] = stop_ok;
    @(negedge clk);
    c     = cyc;
    e.cyc  = c + 3 + CPB/2 + CPB * (db + 1 + hp) + 1;
    e.data = md;
    e.fe   = ~stop_ok;
    e.pe   = (hp == 1) ? ~par_ok : 1'b0;
    if (idx == 0) q0.push_back(e); else q1.push_back(e);
    for (int i = 0; i < nbits * CPB; i++) begin
      if (i > 0) @(negedge clk);
      set_line(idx, frame[i / CPB], (cyc + 1 == c + clr_off));
    end
  endtask

  task automatic glitch(int idx, int len);
    repeat (len) begin
      @(negedge clk);
      set_line(idx, 1'b0, 1'b0);
    end
    idle(20);
  endtask

  // Safety net against a hung run.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int c;
    int idx;
    int kind;
    int gap;
    bit pok;
    bit sok;
    int coff;

    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(rdy0), 32'd0);
    check("reset_data", 32'(d0), 32'd0);
    check("reset_flags", 32'({fe0, pe0, ov0}), 32'd0);
    rst_n = 1'b1;
    idle(10);

    // 8N1 0xA5 and its latency
    send_frame(0, 'hA5, 1'b1, 1'b1, -1, c);
    check("a5_data", 32'(d0), 32'hA5);
    check("a5_rdy", 32'(rdy0), 32'd1);
    check("a5_flags", 32'({fe0, pe0}), 32'd0);
    check("a5_latency", 32'(last_rise0 - c), 32'd156);
    idle(4);
    pulse_clr(0);
    idle(1);
    check("a5_clr_rdy", 32'(rdy0), 32'd0);
    check("a5_clr_data_held", 32'(d0), 32'hA5);

    // 7E1 0x41, good then bad parity
    send_frame(1, 'h41, 1'b1, 1'b1, -1, c);
    check("e41_ok_pe", 32'(pe1), 32'd0);
    check("e41_ok_data", 32'(d1), 32'h41);
    idle(4);
    pulse_clr(1);
    send_frame(1, 'h41, 1'b0, 1'b1, -1, c);
    check("e41_bad_pe", 32'(pe1), 32'd1);
    check("e41_bad_data", 32'(d1), 32'h41);
    idle(4);
    pulse_clr(1);

    // false start then framing error
    glitch(0, 5);
    check("glitch_rdy", 32'(rdy0), 32'd0);
    send_frame(0, 'h3C, 1'b1, 1'b0, -1, c);
    check("ferr_fe", 32'(fe0), 32'd1);
    check("ferr_data", 32'(d0), 32'h3C);
    idle(4);
    pulse_clr(0);

    // overrun
    send_frame(0, 'h11, 1'b1, 1'b1, -1, c);
    idle(3);
    send_frame(0, 'h22, 1'b1, 1'b1, -1, c);
    check("ovr_data", 32'(d0), 32'h22);
    check("ovr_flag", 32'(ov0), 32'd1);
    pulse_clr(0);
    idle(1);
    check("ovr_clr", 32'({rdy0, fe0, pe0, ov0}), 32'd0);

    // clr_rdy in the completion cycle
    send_frame(0, 'h10, 1'b1, 1'b1, -1, c);
    idle(3);
    send_frame(0, 'h55, 1'b1, 1'b1, 156, c);
    check("simul_rdy", 32'(rdy0), 32'd1);
    check("simul_ovr", 32'(ov0), 32'd0);
    check("simul_data", 32'(d0), 32'h55);

    // reset mid-frame, then a clean frame
    @(negedge clk);
    rx0 = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    rx0   = 1'b1;
    @(negedge clk);
    check("midrst_out", 32'({d0, rdy0, fe0, pe0, ov0}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    send_frame(0, 'h99, 1'b1, 1'b1, -1, c);
    check("post_rst_data", 32'(d0), 32'h99);
    check("post_rst_rdy", 32'(rdy0), 32'd1);
    pulse_clr(0);
    idle(5);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      idx  = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        glitch(idx, int'($urandom_range(1, 5)));
      end else begin
        pok  = ($urandom_range(0, 4) != 0);
        sok  = ($urandom_range(0, 5) != 0);
        coff = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10 * CPB)) : -1;
        send_frame(idx, int'($urandom), pok, sok, coff, c);
        gap = sok ? int'($urandom_range(0, 30)) : int'($urandom_range(2, 30));
        if (gap > 0) idle(gap);
      end
    end

    idle(200);
    check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8N1 receiver in the command path from the host serial link. It adds:
- configurable bit period, data width and parity;
- start-bit validation at mid-bit;
- framing, parity and overrun error reporting;
- data and flags that stay stable until the next completed frame.

It sits between the synchronised RX pin and the command decoder, which consumes `rx_data` on `rdy` and acknowledges with `clr_rdy`.

## Interface
Parameters:
- CLK_PER_BIT, 2604: clk cycles per bit (2604 = 50 MHz / 19200 baud); legal range 4..4095.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, PAR_NONE: parity mode of type `parity_e`, one of PAR_NONE, PAR_EVEN or PAR_ODD.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- RX  in  1  asynchronous serial input; idle high
- clr_rdy  in  1  consumer acknowledge; clears `rdy`, `frame_err`, `parity_err` and `overrun`
- rx_data  out  DATA_BITS  last received data word, LSB first on the line
- rdy  out  1  a new frame is available
- frame_err  out  1  the last frame had stop bit = 0
- parity_err  out  1  the last frame had a parity mismatch; always 0 when PARITY = PAR_NONE
- overrun  out  1  sticky; a frame completed while `rdy` was still 1

## Operation
- **Sync:** RX passes through two flops to give `rx_s`. A third flop gives `rx_prev`. All three reset to 1.
- **States:** IDLE, START, DATA, PAR, STOP.
  - IDLE: falling edge (`rx_prev` = 1, `rx_s` = 0) → START. Load the baud counter with HALF = CLK_PER_BIT/2 (integer divide) and clear the bit counter.
  - START: when the baud counter reaches 0, sample `rx_s`.
    - `rx_s` = 1 is a false start → IDLE. No output changes.
    - `rx_s` = 0 → DATA. Reload the baud counter with CLK_PER_BIT − 1.
  - DATA: on each baud counter zero, shift `rx_s` into the MSB of the shift register (right shift) and increment the bit counter.
    - After DATA_BITS samples → PAR if PARITY ≠ PAR_NONE, else → STOP.
  - PAR: one sample, stored as the parity bit → STOP.
  - STOP: one sample, then → IDLE and the completion update is issued.
- **Baud counter:** decrements every cycle in START, DATA, PAR and STOP. It is reloaded with CLK_PER_BIT − 1 on every sample except the final one. Width is $clog2(CLK_PER_BIT).
- **Parity check:** XOR of the data bits and the parity bit.
  - Even mode: error if the XOR is 1.
  - Odd mode: error if the XOR is 0.
- **Completion update (one cycle):**
  - `rx_data` ← shift register.
  - `frame_err` ← ~stop sample.
  - `parity_err` ← parity check result.
  - `rdy` ← 1.
  - `overrun` ← `overrun` | (`rdy` & ~`clr_rdy`).
- **Output stability:** outputs do not change during reception of a subsequent frame. Only a completion update, `clr_rdy` or reset changes them.
- **Break condition:** with RX held low, the receiver completes one frame with `frame_err` = 1. It does not retrigger until RX returns high and then falls again.

## Timing
- **Reset values:** `rx_data` = 0, `rdy` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, state IDLE. Reset mid-frame aborts the frame immediately.
- **Detection:** the detect cycle (entry to START) is 3 clk after the RX pin falls.
- **Sample timing:** sample k (k = 0 is the start bit) occurs HALF + k·CLK_PER_BIT cycles after the detect cycle.
- **Completion latency:** outputs update on the clk edge after the stop sample. `rdy` is high 1 cycle after the stop sample.
- **clr_rdy and completion in the same cycle:** the completion wins. `rdy` = 1, flags take the new frame's values, and `overrun` is not set.
- **clr_rdy alone:** clears `rdy` and all three flags on the next edge. `rx_data` is held.
- **Back-to-back frames:** with one stop bit, the next start edge is detected during IDLE without a lost cycle. STOP exits at the mid-stop-bit sample, so IDLE is reached half a bit early.

## Structure
- Package `uart_pkg` holds:
  - `parity_e` (PAR_NONE, PAR_EVEN, PAR_ODD);
  - `rx_state_e` (IDLE, START, DATA, PAR, STOP);
  - localparam default CLK_PER_BIT = 2604.
- Sub-module `uart_rx_sync` contains the two-flop synchroniser plus the `rx_prev` flop. Outputs are `rx_s` and `fall`. Its reset value is 1.

## Test plan
All scenarios use CLK_PER_BIT = 16.
- **8N1 frame:** send 0xA5 → `rx_data` = 0xA5, `rdy` = 1, `frame_err` = `parity_err` = 0. `rdy` rises 3 + 8 + 9·16 + 1 cycles after the RX fall. `clr_rdy` then clears `rdy`.
- **Even parity:** PARITY = PAR_EVEN, DATA_BITS = 7. Send 0x41 with parity 0 → `parity_err` = 0. Send 0x41 with parity 1 → `parity_err` = 1, data still 0x41.
- **False start and framing error:**
  - A 5-cycle low glitch on RX → no state change past START, `rdy` stays 0.
  - A frame 0x3C with stop = 0 → `frame_err` = 1.
- **Overrun:** send 0x11 then 0x22 without `clr_rdy` → `rx_data` = 0x22, `overrun` = 1. `clr_rdy` clears all.
- **Simultaneous clear and reset:**
  - `clr_rdy` asserted in the completion cycle of frame 0x55 → `rdy` = 1, `overrun` = 0.
  - `rst_n` low mid-frame → all outputs 0. The next clean frame 0x99 is received correctly.
